// File: rtl/mem_access.sv
// MEM stage: non-memory ops pass straight through to WB; loads/stores are
// serialised into byte transfers on the memory controller's 8-bit port while
// the upstream pipeline is held by stall_req_o.
module mem_access #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic              mc_req_o,
  output logic              mc_wr_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  output logic [7:0]        mc_wdata_o,
  input  logic [7:0]        mc_rdata_i,
  input  logic              mc_done_i
);

  localparam logic [7:0] EX_NOP = 8'h00;
  localparam logic [7:0] EX_LB  = 8'h20;
  localparam logic [7:0] EX_LH  = 8'h21;
  localparam logic [7:0] EX_LW  = 8'h23;
  localparam logic [7:0] EX_LBU = 8'h24;
  localparam logic [7:0] EX_LHU = 8'h25;
  localparam logic [7:0] EX_SB  = 8'h28;
  localparam logic [7:0] EX_SH  = 8'h29;
  localparam logic [7:0] EX_SW  = 8'h2b;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic [1:0]        last_idx;
  logic              wreg_eff;
  logic [DATA_W-1:0] load_data;

  // Decode the op class and the index of its final byte.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_idx = 2'd0;
    case (aluop_i)
      EX_LB, EX_LBU: is_load = 1'b1;
      EX_LH, EX_LHU: begin is_load = 1'b1; last_idx = 2'd1; end
      EX_LW:         begin is_load = 1'b1; last_idx = 2'd3; end
      EX_SB:         is_store = 1'b1;
      EX_SH:         begin is_store = 1'b1; last_idx = 2'd1; end
      EX_SW:         begin is_store = 1'b1; last_idx = 2'd3; end
      default:       ;
    endcase
    is_mem   = is_load | is_store;
    wreg_eff = wreg_i && (wd_i != NOP_REG_ADDR);
  end

  // Sign/zero-extend the assembled load buffer for write-back.
  always_comb begin
    load_data = buf_q;
    case (aluop_i)
      EX_LB:   load_data = {{24{buf_q[7]}}, buf_q[7:0]};
      EX_LBU:  load_data = {24'd0, buf_q[7:0]};
      EX_LH:   load_data = {{16{buf_q[15]}}, buf_q[15:0]};
      EX_LHU:  load_data = {16'd0, buf_q[15:0]};
      default: load_data = buf_q;
    endcase
  end

  // Next-state: walk bytes on each controller completion, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          state_d = BUSY;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      BUSY: begin
        if (mc_done_i) begin
          if (is_load) buf_d[{cnt_q, 3'b000} +: 8] = mc_rdata_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_idx) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, byte counter and load buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mc_req_o    = 1'b0;
    mc_wr_o     = 1'b0;
    mc_addr_o   = '0;
    mc_wdata_o  = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            stall_req_o = 1'b1;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_eff;
            wdata_o = wdata_i;
          end
        end
        BUSY: begin
          stall_req_o = 1'b1;
          mc_req_o    = 1'b1;
          mc_wr_o     = is_store;
          mc_addr_o   = mem_addr_i + ADDR_W'(cnt_q);
          mc_wdata_o  = wdata_i[{cnt_q, 3'b000} +: 8];
        end
        DONE: begin
          if (is_load) begin
            wd_o    = wd_i;
            wreg_o  = wreg_eff;
            wdata_o = load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a cycle-driven driver plays both the EX stage and the
// memory controller, derives expected outputs from op semantics and a byte
// memory array, and a single negedge process compares them.
module tb_mem_access;

  localparam logic [7:0] EX_NOP = 8'h00;
  localparam logic [7:0] EX_LB  = 8'h20;
  localparam logic [7:0] EX_LH  = 8'h21;
  localparam logic [7:0] EX_LW  = 8'h23;
  localparam logic [7:0] EX_LBU = 8'h24;
  localparam logic [7:0] EX_LHU = 8'h25;
  localparam logic [7:0] EX_SB  = 8'h28;
  localparam logic [7:0] EX_SH  = 8'h29;
  localparam logic [7:0] EX_SW  = 8'h2b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [7:0]  aluop_i = EX_NOP;
  logic [31:0] mem_addr_i = '0;
  logic [7:0]  mc_rdata_i = '0;
  logic        mc_done_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        mc_req_o;
  logic        mc_wr_o;
  logic [31:0] mc_addr_o;
  logic [7:0]  mc_wdata_o;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .mc_req_o(mc_req_o), .mc_wr_o(mc_wr_o), .mc_addr_o(mc_addr_o),
    .mc_wdata_o(mc_wdata_o), .mc_rdata_i(mc_rdata_i), .mc_done_i(mc_done_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle, set by the driver after each edge.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_req, exp_chk_mc, exp_wr, exp_chk_wd, exp_wreg, exp_done;
  logic [31:0] exp_addr, exp_wdata;
  logic [7:0]  exp_wb;
  logic [4:0]  exp_wd;

  int          stall_run = 0;
  int          last_run = 0;
  logic [31:0] last_result = '0;

  logic [7:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // Compare DUT outputs against the expectation once per cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("stall_req_o", 32'(stall_req_o), 32'(exp_stall));
      check("mc_req_o", 32'(mc_req_o), 32'(exp_req));
      if (exp_chk_mc) begin
        check("mc_wr_o", 32'(mc_wr_o), 32'(exp_wr));
        check("mc_addr_o", mc_addr_o, exp_addr);
        check("mc_wdata_o", 32'(mc_wdata_o), 32'(exp_wb));
      end
      if (exp_chk_wd) check("wd_o", 32'(wd_o), 32'(exp_wd));
      check("wreg_o", 32'(wreg_o), 32'(exp_wreg));
      check("wdata_o", wdata_o, exp_wdata);
      if (exp_done) last_result = wdata_o;
    end
    if (stall_req_o === 1'b1) begin
      stall_run++;
    end else begin
      if (stall_run != 0) last_run = stall_run;
      stall_run = 0;
    end
  end

  task automatic expect_o(input logic s, input logic r, input logic cm, input logic w,
                          input logic [31:0] a, input logic [7:0] b, input logic cw,
                          input logic [4:0] d, input logic g, input logic [31:0] v,
                          input logic dn);
    exp_valid = 1'b1;
    exp_stall = s;  exp_req = r;  exp_chk_mc = cm; exp_wr = w;
    exp_addr = a;   exp_wb = b;   exp_chk_wd = cw; exp_wd = d;
    exp_wreg = g;   exp_wdata = v; exp_done = dn;
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int size_of(input logic [7:0] op);
    case (op)
      EX_LB, EX_LBU, EX_SB: return 1;
      EX_LH, EX_LHU, EX_SH: return 2;
      EX_LW, EX_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic is_ld(input logic [7:0] op);
    return op == EX_LB || op == EX_LBU || op == EX_LH || op == EX_LHU || op == EX_LW;
  endfunction

  function automatic logic [31:0] extend(input logic [7:0] op, input logic [31:0] v);
    case (op)
      EX_LB:   return (v & 32'hFF) | ((v & 32'h80) != 0 ? 32'hFFFFFF00 : 32'h0);
      EX_LBU:  return v & 32'hFF;
      EX_LH:   return (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF0000 : 32'h0);
      EX_LHU:  return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  // Advance one cycle; a completing store byte is written to the bench memory
  // from what the DUT actually presents on the controller port.
  task automatic step(input logic store_done);
    @(negedge clk);
    if (store_done) mem[mc_addr_o] = mc_wdata_o;
    @(posedge clk);
    #1;
  endtask

  // Present one op and act as the controller with per-byte latencies l0..l3.
  // abort_byte >= 0 pulses reset on the first cycle of that byte.
  task automatic run_op(input logic [7:0] op, input logic [4:0] wd, input logic we,
                        input logic [31:0] wdata, input logic [31:0] addr,
                        input int l0, input int l1, input int l2, input int l3,
                        input int abort_byte);
    int          lat [4];
    int          sz;
    logic        ld, st, dn;
    logic [31:0] v;
    logic [7:0]  b;
    lat = '{l0, l1, l2, l3};
    sz  = size_of(op);
    ld  = is_ld(op);
    st  = (sz != 0) && !ld;
    aluop_i = op; wd_i = wd; wreg_i = we; wdata_i = wdata; mem_addr_i = addr; rst = 1'b0;
    mc_done_i = 1'($urandom); mc_rdata_i = 8'($urandom);
    if (sz == 0) begin
      expect_o(0, 0, 0, 0, 0, 0, 1, wd, we && (wd != 0), wdata, 0);
      step(0);
      return;
    end
    expect_o(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0);
    v = 0;
    for (int i = 0; i < sz; i++) begin
      for (int c = 0; c < lat[i]; c++) begin
        if (i == abort_byte) begin
          rst = 1'b1; mc_done_i = 1'($urandom);
          expect_o(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
          step(0);
          rst = 1'b0; aluop_i = EX_NOP; wreg_i = 1'b0; mc_done_i = 1'b0;
          expect_o(0, 0, 0, 0, 0, 0, 1, wd, 0, wdata, 0);
          step(0);
          return;
        end
        dn = (c == lat[i] - 1);
        mc_done_i = dn;
        if (ld && dn) begin
          b = rd(addr + 32'(i));
          mc_rdata_i = b;
          v = v | (32'(b) << (8 * i));
        end else begin
          mc_rdata_i = 8'($urandom);
        end
        expect_o(1, 1, 1, st, addr + 32'(i), wdata[8*i +: 8], 1, 0, 0, 0, 0);
        step(dn && st);
      end
    end
    mc_done_i = 1'($urandom); mc_rdata_i = 8'($urandom);
    if (ld) expect_o(0, 0, 0, 0, 0, 0, 1, wd, we && (wd != 0), extend(op, v), 1);
    else    expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0);
  endtask

  logic [7:0] ops [9] = '{EX_NOP, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW};

  initial begin
    // Reset: outputs forced low even with a load presented.
    aluop_i = EX_LW; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF; mc_done_i = 1'b1;
    expect_o(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0);
    step(0);

    // Pass-through.
    run_op(EX_NOP, 5'd5, 1'b1, 32'h1234, 32'h0, 1, 1, 1, 1, -1);
    // No-write register target.
    run_op(EX_NOP, 5'd0, 1'b1, 32'h55AA, 32'h0, 1, 1, 1, 1, -1);

    // LW with single-cycle byte completions.
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op(EX_LW, 5'd3, 1'b1, 32'h0, 32'h100, 1, 1, 1, 1, -1);
    check("lw_result", last_result, 32'h12345678);
    check("lw_stall_cycles", 32'(last_run), 32'd5);

    // Byte/half extension.
    mem[32'h7] = 8'h80;
    run_op(EX_LB, 5'd4, 1'b1, 32'h0, 32'h7, 2, 1, 1, 1, -1);
    check("lb_result", last_result, 32'hFFFFFF80);
    run_op(EX_LBU, 5'd4, 1'b1, 32'h0, 32'h7, 1, 1, 1, 1, -1);
    check("lbu_result", last_result, 32'h00000080);
    mem[32'h10] = 8'h00; mem[32'h11] = 8'h80;
    run_op(EX_LH, 5'd6, 1'b1, 32'h0, 32'h10, 1, 2, 1, 1, -1);
    check("lh_result", last_result, 32'hFFFF8000);

    // SH across the address wrap.
    run_op(EX_SH, 5'd7, 1'b1, 32'hABCD, 32'hFFFFFFFF, 1, 1, 1, 1, -1);
    check("sh_byte_hi_addr", 32'(rd(32'hFFFFFFFF)), 32'hCD);
    check("sh_byte_wrap", 32'(rd(32'h0)), 32'hAB);

    // SW with a slow controller.
    run_op(EX_SW, 5'd8, 1'b1, 32'hCAFEF00D, 32'h40, 3, 3, 3, 3, -1);
    check("sw_stall_cycles", 32'(last_run), 32'd13);
    check("sw_byte3", 32'(rd(32'h43)), 32'hCA);

    // Reset during byte 2 of an LW, then a normal LW.
    run_op(EX_LW, 5'd2, 1'b1, 32'h0, 32'h100, 1, 2, 2, 1, 1);
    mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33; mem[32'h203] = 8'h44;
    run_op(EX_LW, 5'd2, 1'b1, 32'h0, 32'h200, 2, 1, 3, 1, -1);
    check("after_abort_lw", last_result, 32'h44332211);

    // Randomised op stream against the byte-memory model.
    for (int n = 0; n < 200; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 8)];
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 63));
      run_op(op, 5'($urandom), 1'($urandom), $urandom, a,
             $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(1, 4), $urandom_range(1, 4),
             ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
    end

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
